// File: rtl/cm163_out_sampler.sv
// cm163_out_sampler: timestamps changes on the CM163 result bits {q,r,s,t,u}
// and queues them in a 4-entry FIFO with a ready/valid output and sticky overflow.
module cm163_out_sampler (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        q,
    input  logic        r,
    input  logic        s,
    input  logic        t,
    input  logic        u,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [12:0] out_data,
    output logic [2:0]  count,
    output logic        ovf,
    input  logic        clr_ovf
);

    localparam int unsigned VEC_W   = 5;
    localparam int unsigned STAMP_W = 8;
    localparam int unsigned ENTRY_W = STAMP_W + VEC_W;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned PTR_W   = 2;
    localparam int unsigned CNT_W   = 3;

    logic [STAMP_W-1:0] stamp;
    logic [VEC_W-1:0]   last_vec;
    logic               first;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [ENTRY_W-1:0] mem [DEPTH];

    logic [VEC_W-1:0]   vec;
    logic               ev;
    logic               pop;
    logic               full;
    logic               push;
    logic               overflow;
    logic [PTR_W-1:0]   wr_next;
    logic [PTR_W-1:0]   rd_next;
    logic [CNT_W-1:0]   count_next;
    logic               ovf_next;
    logic [ENTRY_W-1:0] mem_next [DEPTH];

    // Event detection, FIFO push/pop decisions and next-state values
    always_comb begin
        vec        = {q, r, s, t, u};
        ev         = in_valid && (first || (vec != last_vec));
        pop        = out_valid && out_ready;
        full       = (count == CNT_W'(DEPTH));
        push       = ev && (!full || pop);
        overflow   = ev && full && !pop;
        mem_next   = mem;
        wr_next    = wr_ptr;
        rd_next    = rd_ptr;
        count_next = count;
        ovf_next   = ovf;

        if (push) begin
            mem_next[wr_ptr] = {stamp, vec};
            wr_next          = wr_ptr + PTR_W'(1);
        end
        if (pop) begin
            rd_next = rd_ptr + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase

        // A new overflow on the same edge as a clear keeps the flag set
        if (overflow) begin
            ovf_next = 1'b1;
        end else if (clr_ovf) begin
            ovf_next = 1'b0;
        end
    end

    // State registers; out_data is registered from the next head entry
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stamp     <= '0;
            last_vec  <= '0;
            first     <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            ovf       <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            stamp <= stamp + STAMP_W'(1);
            if (in_valid) begin
                last_vec <= vec;
                first    <= 1'b0;
            end
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= mem_next[i];
            end
            wr_ptr    <= wr_next;
            rd_ptr    <= rd_next;
            count     <= count_next;
            out_valid <= (count_next != '0);
            out_data  <= mem_next[rd_next];
            ovf       <= ovf_next;
        end
    end

endmodule

// File: tb/tb_cm163_out_sampler.sv
// Scoreboard bench for cm163_out_sampler: directed stimulus pushes expected
// entries, a negedge monitor pops and compares every accepted FIFO head.
module tb_cm163_out_sampler;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        q, r, s, t, u;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] out_data;
    logic [2:0]  count;
    logic        ovf;
    logic        clr_ovf;

    int n_checks = 0;
    int n_errors = 0;
    logic [12:0] exp_q[$];

    cm163_out_sampler dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .q         (q),
        .r         (r),
        .s         (s),
        .t         (t),
        .u         (u),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .ovf       (ovf),
        .clr_ovf   (clr_ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then move to just after the next rising edge
    task automatic step(input logic iv, input logic [4:0] v, input logic rdy, input logic clr);
        in_valid  = iv;
        {q, r, s, t, u} = v;
        out_ready = rdy;
        clr_ovf   = clr;
        @(posedge clock);
        #1;
    endtask

    // Monitor: every head accepted by the consumer must match the scoreboard
    always @(negedge clock) begin
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected: got %h expected none", out_data);
            end else begin
                check("sb_head", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        {q, r, s, t, u} = 5'd0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rst_valid", 13'(out_valid), 13'd0);
        check("rst_count", 13'(count), 13'd0);
        check("rst_ovf",   13'(ovf), 13'd0);
        check("rst_data",  out_data, 13'h0000);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Edge 0: first sample is always an event with stamp 0
        exp_q.push_back({8'd0, 5'b00000});
        step(1'b1, 5'b00000, 1'b0, 1'b0);
        check("first_valid", 13'(out_valid), 13'd1);
        check("first_count", 13'(count), 13'd1);
        check("first_data",  out_data, 13'h0000);

        // Edges 1..10: unchanged vec raises no events
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 5'b00000, 1'b0, 1'b0);
            check("nochange_count", 13'(count), 13'd1);
        end

        // Edge 11: change is recorded with stamp 11
        exp_q.push_back({8'd11, 5'b10001});
        step(1'b1, 5'b10001, 1'b0, 1'b0);
        check("change_count", 13'(count), 13'd2);

        // Edges 12,13: drain
        step(1'b0, 5'd0, 1'b1, 1'b0);
        step(1'b0, 5'd0, 1'b1, 1'b0);
        check("drain1_count", 13'(count), 13'd0);
        check("drain1_valid", 13'(out_valid), 13'd0);

        // Edges 14..19: six distinct vecs with consumer stalled
        exp_q.push_back({8'd14, 5'd1});
        exp_q.push_back({8'd15, 5'd2});
        exp_q.push_back({8'd16, 5'd3});
        exp_q.push_back({8'd17, 5'd4});
        step(1'b1, 5'd1, 1'b0, 1'b0);
        step(1'b1, 5'd2, 1'b0, 1'b0);
        step(1'b1, 5'd3, 1'b0, 1'b0);
        step(1'b1, 5'd4, 1'b0, 1'b0);
        check("fill_ovf_pre", 13'(ovf), 13'd0);
        step(1'b1, 5'd5, 1'b0, 1'b0);
        step(1'b1, 5'd6, 1'b0, 1'b0);
        check("ovf_count", 13'(count), 13'd4);
        check("ovf_flag",  13'(ovf), 13'd1);
        check("ovf_head",  out_data, {8'd14, 5'd1});

        // Edge 20: clear overflow
        step(1'b0, 5'd0, 1'b0, 1'b1);
        check("clr_ovf", 13'(ovf), 13'd0);
        check("clr_count", 13'(count), 13'd4);

        // Edge 21: full, pop and event on the same edge
        exp_q.push_back({8'd21, 5'd7});
        step(1'b1, 5'd7, 1'b1, 1'b0);
        check("fullpop_count", 13'(count), 13'd4);
        check("fullpop_ovf",   13'(ovf), 13'd0);
        check("fullpop_head",  out_data, {8'd15, 5'd2});

        // Edges 22..25: drain
        for (int i = 0; i < 4; i++) step(1'b0, 5'd0, 1'b1, 1'b0);
        check("drain2_count", 13'(count), 13'd0);

        // Edges 26..254 idle, then events at stamps 255 and 0
        for (int e = 26; e < 255; e++) step(1'b0, 5'd0, 1'b0, 1'b0);
        exp_q.push_back({8'hFF, 5'd8});
        step(1'b1, 5'd8, 1'b0, 1'b0);
        exp_q.push_back({8'h00, 5'd9});
        step(1'b1, 5'd9, 1'b0, 1'b0);
        check("wrap_count", 13'(count), 13'd2);
        check("wrap_head",  out_data, {8'hFF, 5'd8});
        step(1'b0, 5'd0, 1'b1, 1'b0);
        step(1'b0, 5'd0, 1'b1, 1'b0);

        // Three events left queued, then asynchronous reset between edges
        step(1'b1, 5'd10, 1'b0, 1'b0);
        step(1'b1, 5'd11, 1'b0, 1'b0);
        step(1'b1, 5'd12, 1'b0, 1'b0);
        check("pre_rst_count", 13'(count), 13'd3);
        in_valid = 1'b0;
        @(negedge clock);
        #1 reset = 1'b1;
        #1;
        check("arst_valid", 13'(out_valid), 13'd0);
        check("arst_count", 13'(count), 13'd0);
        check("arst_data",  out_data, 13'h0000);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // After release: vec 0 still an event (first), stamp restarts at 0
        exp_q.push_back({8'd0, 5'd0});
        exp_q.push_back({8'd1, 5'd13});
        exp_q.push_back({8'd2, 5'd14});
        exp_q.push_back({8'd3, 5'd15});
        step(1'b1, 5'd0, 1'b0, 1'b0);
        check("post_rst_count", 13'(count), 13'd1);
        check("post_rst_head",  out_data, {8'd0, 5'd0});
        step(1'b1, 5'd13, 1'b0, 1'b0);
        step(1'b1, 5'd14, 1'b0, 1'b0);
        step(1'b1, 5'd15, 1'b0, 1'b0);

        // Overflow and clear on the same edge: set wins
        step(1'b1, 5'd16, 1'b0, 1'b1);
        check("setwins_ovf",   13'(ovf), 13'd1);
        check("setwins_count", 13'(count), 13'd4);
        step(1'b0, 5'd0, 1'b0, 1'b1);
        check("clr2_ovf", 13'(ovf), 13'd0);

        for (int i = 0; i < 4; i++) step(1'b0, 5'd0, 1'b1, 1'b0);
        check("drain3_count", 13'(count), 13'd0);
        check("sb_empty", 13'(exp_q.size()), 13'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
